// File: rtl/trace_issue_queue.sv
// Trace issue queue: buffers parsed trace records in a show-ahead FIFO, issues them to the
// cache, executes local CLEAR commands and raises a sticky done once the trace is fully issued.
module trace_issue_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CMD_W  = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [ADDR_W-1:0] out_addr,
  output logic              clear_stats,
  output logic              done,
  output logic [31:0]       issued_count,
  output logic [15:0]       dropped_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]      PtrOne     = (PtrW + 1)'(1);
  localparam logic [CMD_W-1:0]   CmdSnoop   = CMD_W'(4);
  localparam logic [CMD_W-1:0]   CmdClear   = CMD_W'(5);
  localparam logic [CMD_W-1:0]   CmdNop     = CMD_W'(6);
  localparam logic [CMD_W-1:0]   CmdIllegal = CMD_W'(7);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic [CMD_W-1:0]  cmd_mem_q  [DEPTH];
  logic [CMD_W-1:0]  cmd_mem_d  [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [31:0]       issued_q, issued_d;
  logic [15:0]       dropped_q, dropped_d;

  logic              full, empty;
  logic              accept, push, pop, out_fire;
  logic              head_fwd, head_clear;
  logic [CMD_W-1:0]  head_cmd;
  logic [ADDR_W-1:0] head_addr;

  assign full  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                 (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign head_cmd   = cmd_mem_q[rd_ptr_q[PtrW-1:0]];
  assign head_addr  = addr_mem_q[rd_ptr_q[PtrW-1:0]];
  assign head_fwd   = !empty && (head_cmd <= CmdSnoop);
  assign head_clear = !empty && (head_cmd == CmdClear);

  assign accept   = in_valid && in_ready;
  // NOP and illegal records are consumed at the input and never occupy a slot.
  assign push     = accept && (in_cmd != CmdNop) && (in_cmd != CmdIllegal);
  assign out_fire = out_valid && out_ready;
  assign pop      = out_fire || clear_stats;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!in_eof) begin
            state_d = StRun;
          end else if (push) begin
            state_d = StDrain;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (accept && in_eof) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // An empty FIFO implies out_valid is low, so no handshake can be pending.
        if (empty) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    clear_stats = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        in_ready    = rst_n && !full;
        out_valid   = head_fwd;
        clear_stats = head_clear;
      end
      StDrain: begin
        out_valid   = head_fwd;
        clear_stats = head_clear;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
    out_cmd  = out_valid ? head_cmd  : '0;
    out_addr = out_valid ? head_addr : '0;
  end

  assign issued_count  = issued_q;
  assign dropped_count = dropped_q;

  // FIFO and counter next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cmd_mem_d  = cmd_mem_q;
    addr_mem_d = addr_mem_q;
    issued_d   = issued_q;
    dropped_d  = dropped_q;
    if (push) begin
      cmd_mem_d[wr_ptr_q[PtrW-1:0]]  = in_cmd;
      addr_mem_d[wr_ptr_q[PtrW-1:0]] = in_addr;
      wr_ptr_d                       = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (out_fire && (issued_q != '1)) begin
      issued_d = issued_q + 32'd1;
    end
    if (accept && (in_cmd == CmdIllegal) && (dropped_q != '1)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_mem_q  <= '{default: '0};
      addr_mem_q <= '{default: '0};
      issued_q   <= '0;
      dropped_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmd_mem_q  <= cmd_mem_d;
      addr_mem_q <= addr_mem_d;
      issued_q   <= issued_d;
      dropped_q  <= dropped_d;
    end
  end

endmodule

// File: tb/tb_trace_issue_queue.sv
// Bench for trace_issue_queue: a queue-based behavioural model checked every cycle,
// plus directed traces with hand-computed end-of-trace expectations.
module tb_trace_issue_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CMD_W-1:0]  in_cmd = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              in_eof = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CMD_W-1:0]  out_cmd;
  logic [ADDR_W-1:0] out_addr;
  logic              clear_stats;
  logic              done;
  logic [31:0]       issued_count;
  logic [15:0]       dropped_count;

  int n_vec    = 0;
  int n_err    = 0;
  int clr_seen = 0;
  int rdy_mode = 0;  // 0: out_ready held by the test, 2: toggles every cycle

  trace_issue_queue #(
    .ADDR_W(ADDR_W),
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_addr      (in_addr),
    .in_eof       (in_eof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cmd      (out_cmd),
    .out_addr     (out_addr),
    .clear_stats  (clear_stats),
    .done         (done),
    .issued_count (issued_count),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the queue holds every buffered record in arrival order.
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
  } rec_t;
  typedef enum int {MIdle, MRun, MDrain, MDone} phase_e;

  rec_t        mq[$];
  phase_e      ph = MIdle;
  int unsigned m_issued = 0;
  int unsigned m_dropped = 0;

  // Inputs change just after a rising edge, so at the falling edge they are what the next
  // rising edge will sample: compare first, then advance the model across that edge.
  always @(negedge clk) begin
    bit   e_rdy, e_val, e_clr, acc, was_empty;
    rec_t r;
    if (!rst_n) begin
      mq.delete();
      ph        = MIdle;
      m_issued  = 0;
      m_dropped = 0;
    end
    e_rdy = rst_n && (ph == MIdle || ph == MRun) && (mq.size() < int'(DEPTH));
    e_val = (ph != MDone) && (mq.size() > 0) && (mq[0].cmd <= 3'd4);
    e_clr = (ph != MDone) && (mq.size() > 0) && (mq[0].cmd == 3'd5);
    check("in_ready", 64'(in_ready), 64'(e_rdy));
    check("out_valid", 64'(out_valid), 64'(e_val));
    check("clear_stats", 64'(clear_stats), 64'(e_clr));
    check("done", 64'(done), 64'(ph == MDone));
    check("issued_count", 64'(issued_count), 64'(m_issued));
    check("dropped_count", 64'(dropped_count), 64'(m_dropped));
    if (e_val) begin
      check("out_cmd", 64'(out_cmd), 64'(mq[0].cmd));
      check("out_addr", 64'(out_addr), 64'(mq[0].addr));
    end else if (!rst_n) begin
      check("out_cmd_rst", 64'(out_cmd), 64'd0);
      check("out_addr_rst", 64'(out_addr), 64'd0);
    end
    if (clear_stats === 1'b1) clr_seen++;
    if (rst_n) begin
      acc       = in_valid && e_rdy;
      was_empty = (mq.size() == 0);
      if ((e_val && out_ready) || e_clr) void'(mq.pop_front());
      if (e_val && out_ready) m_issued++;
      if (acc) begin
        if (in_cmd == 3'd7) m_dropped++;
        else if (in_cmd != 3'd6) begin
          r.cmd  = in_cmd;
          r.addr = in_addr;
          mq.push_back(r);
        end
      end
      case (ph)
        MIdle:  if (acc) ph = !in_eof ? MRun : ((in_cmd == 3'd6 || in_cmd == 3'd7) ? MDone : MDrain);
        MRun:   if (acc && in_eof) ph = MDrain;
        MDrain: if (was_empty) ph = MDone;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 2) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic eof);
    bit took = 1'b0;
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_addr  = addr;
    in_eof   = eof;
    for (int i = 0; i < 200 && !took; i++) begin
      took = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_cmd   = '0;
    in_addr  = '0;
    in_eof   = 1'b0;
    check("send_accepted", 64'(took), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values and a basic three-record trace.
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_issued", 64'(issued_count), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(3'd0, 32'h0000_1000, 1'b0);
    send(3'd1, 32'h0000_2000, 1'b0);
    send(3'd0, 32'h0000_3000, 1'b1);
    repeat (3) tick();
    check("t1_issued", 64'(issued_count), 64'd3);
    check("t1_done", 64'(done), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd0);

    // Fill to full with the cache stalled, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'd0, 32'(32'h100 * (i + 1)), 1'b0);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    check("t2_head_addr", 64'(out_addr), 64'h100);
    check("t2_head_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_cmd   = 3'd1;
    in_addr  = 32'h900;
    in_eof   = 1'b1;
    repeat (3) tick();
    check("t2_ninth_blocked", 64'(in_ready), 64'd0);
    check("t2_head_hold", 64'(out_addr), 64'h100);
    out_ready = 1'b1;
    send(3'd1, 32'h900, 1'b1);
    repeat (15) tick();
    check("t2_issued", 64'(issued_count), 64'd9);
    check("t2_done", 64'(done), 64'd1);

    // Twenty records across pointer wrap with a toggling sink.
    do_reset();
    out_ready = 1'b0;
    rdy_mode  = 2;
    for (int i = 0; i < 20; i++) send(3'(i % 5), 32'hA000_0000 + 32'(i * 4), i == 19);
    repeat (50) tick();
    rdy_mode = 0;
    check("t3_issued", 64'(issued_count), 64'd20);
    check("t3_done", 64'(done), 64'd1);

    // CLEAR records pulse clear_stats and are never issued.
    do_reset();
    out_ready = 1'b1;
    clr_seen  = 0;
    send(3'd0, 32'h10, 1'b0);
    send(3'd5, 32'h20, 1'b0);
    send(3'd5, 32'h30, 1'b0);
    send(3'd1, 32'h40, 1'b1);
    repeat (10) tick();
    check("t4_issued", 64'(issued_count), 64'd2);
    check("t4_clear_pulses", 64'(clr_seen), 64'd2);
    check("t4_done", 64'(done), 64'd1);

    // Illegal and NOP records interleaved with READs.
    do_reset();
    send(3'd0, 32'h1000, 1'b0);
    send(3'd7, 32'h2000, 1'b0);
    send(3'd0, 32'h3000, 1'b0);
    send(3'd6, 32'h4000, 1'b0);
    send(3'd0, 32'h5000, 1'b0);
    send(3'd0, 32'h6000, 1'b1);
    repeat (10) tick();
    check("t5_issued", 64'(issued_count), 64'd4);
    check("t5_dropped", 64'(dropped_count), 64'd1);
    check("t5_done", 64'(done), 64'd1);

    // Asynchronous reset with records buffered, then a fresh trace.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'd1, 32'(32'hB00 + i), 1'b0);
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    check("t6_pre_addr", 64'(out_addr), 64'hB00);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_addr", 64'(out_addr), 64'd0);
    check("t6_async_in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_rel_in_ready", 64'(in_ready), 64'd1);
    check("t6_rel_done", 64'(done), 64'd0);
    out_ready = 1'b1;
    send(3'd0, 32'hC000, 1'b0);
    send(3'd2, 32'hC004, 1'b1);
    repeat (8) tick();
    check("t6_issued", 64'(issued_count), 64'd2);
    check("t6_done", 64'(done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
